// File: rtl/lcd_char_driver.sv
// lcd_char_driver: HD44780 8-bit write-only driver. Waits out power-up, runs the
// four-command init sequence, then refreshes both 16-char lines forever from an
// external character source addressed by index.
// Optional feature: define LCD_FRAME_PULSE_EN to add the frame_done output.
module lcd_char_driver #(
   parameter int PWR_WAIT = 1500000,
   parameter int E_PULSE  = 12,
   parameter int CMD_WAIT = 2500,
   parameter int CLR_WAIT = 100000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [4:0] index,
   input  logic [7:0] char_in,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       init_done
`ifdef LCD_FRAME_PULSE_EN
   ,
   output logic       frame_done
`endif
);

   // Zero-valued timing parameters behave as one cycle.
   localparam int PW   = (PWR_WAIT < 1) ? 1 : PWR_WAIT;
   localparam int EP   = (E_PULSE  < 1) ? 1 : E_PULSE;
   localparam int CW   = (CMD_WAIT < 1) ? 1 : CMD_WAIT;
   localparam int CLW  = (CLR_WAIT < 1) ? 1 : CLR_WAIT;
   localparam int M1   = (PW > EP) ? PW : EP;
   localparam int M2   = (CW > CLW) ? CW : CLW;
   localparam int MAXP = (M1 > M2) ? M1 : M2;
   localparam int CNT_W = (MAXP < 2) ? 1 : $clog2(MAXP + 1);

   localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PW - 1);
   localparam logic [CNT_W-1:0] EP_LAST  = CNT_W'(EP - 1);
   localparam logic [CNT_W-1:0] CW_LAST  = CNT_W'(CW - 1);
   localparam logic [CNT_W-1:0] CLW_LAST = CNT_W'(CLW - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   typedef enum logic [2:0] {
      S_PWR, S_INIT, S_ADDR, S_FETCH, S_SETUP, S_EHIGH, S_WAIT
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [1:0]       init_step, step_nx;
   logic [4:0]       index_nx;
   logic             e_nx, rs_nx, done_nx;
   logic [7:0]       data_nx;
   logic [CNT_W-1:0] wait_last;
   logic             wait_end;

   assign lcd_rw = 1'b0;

   // The only long wait is the one following the clear command (last init step).
   assign wait_last = (!init_done && init_step == 2'd3) ? CLW_LAST : CW_LAST;
   assign wait_end  = (state == S_WAIT) && (cnt == wait_last);

   // State and all bus outputs are registered so lcd_e/rs/data are glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_PWR;
         cnt       <= '0;
         init_step <= 2'd0;
         index     <= 5'd0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= 8'h00;
         init_done <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         init_step <= step_nx;
         index     <= index_nx;
         lcd_e     <= e_nx;
         lcd_rs    <= rs_nx;
         lcd_data  <= data_nx;
         init_done <= done_nx;
      end
   end

   // Next-state logic; index is bumped as the fetch completes, so after slot 15
   // it reads 16 (line 2 address) and after slot 31 it has wrapped to 0.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      step_nx  = init_step;
      index_nx = index;
      e_nx     = lcd_e;
      rs_nx    = lcd_rs;
      data_nx  = lcd_data;
      done_nx  = init_done;
      case (state)
         S_PWR: begin
            if (cnt == PW_LAST) begin
               cnt_nx   = '0;
               state_nx = S_INIT;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         S_INIT: begin
            rs_nx = 1'b0;
            case (init_step)
               2'd0:    data_nx = 8'h38;
               2'd1:    data_nx = 8'h0C;
               2'd2:    data_nx = 8'h06;
               default: data_nx = 8'h01;
            endcase
            state_nx = S_SETUP;
         end
         S_ADDR: begin
            rs_nx    = 1'b0;
            data_nx  = {1'b1, index[4], 6'b0};
            state_nx = S_SETUP;
         end
         S_FETCH: begin
            if (cnt == ONE) begin
               cnt_nx   = '0;
               rs_nx    = 1'b1;
               data_nx  = char_in;
               index_nx = index + 5'd1;
               state_nx = S_SETUP;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         S_SETUP: begin
            e_nx     = 1'b1;
            state_nx = S_EHIGH;
         end
         S_EHIGH: begin
            if (cnt == EP_LAST) begin
               cnt_nx   = '0;
               e_nx     = 1'b0;
               state_nx = S_WAIT;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         S_WAIT: begin
            if (wait_end) begin
               cnt_nx = '0;
               if (!init_done) begin
                  if (init_step == 2'd3) begin
                     done_nx  = 1'b1;
                     state_nx = S_ADDR;
                  end else begin
                     step_nx  = init_step + 2'd1;
                     state_nx = S_INIT;
                  end
               end else if (lcd_rs && index[3:0] == 4'd0) begin
                  state_nx = S_ADDR;
               end else begin
                  state_nx = S_FETCH;
               end
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         default: state_nx = S_PWR;
      endcase
   end

`ifdef LCD_FRAME_PULSE_EN
   // One-cycle pulse as the wait after the slot-31 write ends (index already wrapped).
   always_ff @(posedge clk) begin
      if (rst) frame_done <= 1'b0;
      else     frame_done <= wait_end && init_done && lcd_rs && (index == 5'd0);
   end
`endif

endmodule

// File: doc/lcd_char_driver.md
LCD_CHAR_DRIVER -- requirements
Module: lcd_char_driver

Interface
REQ-001 SHALL have parameter PWR_WAIT, default 1500000, power-up idle in clk cycles (30 ms at 50 MHz).
REQ-002 SHALL have parameter E_PULSE, default 12, lcd_e high width in cycles.
REQ-003 SHALL have parameter CMD_WAIT, default 2500, post-transaction wait in cycles, all commands except clear.
REQ-004 SHALL have parameter CLR_WAIT, default 100000, post-transaction wait in cycles after clear (0x01).
REQ-005 SHALL have port: clk  input  1  single clock, all logic on posedge.
REQ-006 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port: index  output  5  character slot requested from the character source; 0-15 line 1, 16-31 line 2.
REQ-008 SHALL have port: char_in  input  8  ASCII byte for index, valid 2 cycles after index changes.
REQ-009 SHALL have port: lcd_e  output  1  HD44780 enable strobe.
REQ-010 SHALL have port: lcd_rs  output  1  0 = command, 1 = data.
REQ-011 SHALL have port: lcd_rw  output  1  tied 0 (write only).
REQ-012 SHALL have port: lcd_data  output  8  8-bit LCD bus.
REQ-013 SHALL have port: init_done  output  1  high once the init sequence completes, until reset.

Function
REQ-014 SHALL run FSM states PWR, INIT, ADDR, FETCH, SETUP, EHIGH, WAIT.
REQ-015 PWR SHALL count PWR_WAIT cycles with lcd_e=0, then enter INIT.
REQ-016 INIT SHALL issue the commands 0x38, 0x0C, 0x06, 0x01 in order (rs=0), each as one bus transaction.
REQ-017 Bus transaction SHALL consist of: SETUP 1 cycle (rs/data driven, e=0), EHIGH for E_PULSE cycles (e=1), then WAIT for CMD_WAIT cycles (CLR_WAIT after 0x01) with e=0.
REQ-018 lcd_rs and lcd_data SHALL stay stable from SETUP through the end of WAIT.
REQ-019 init_done SHALL rise in the cycle following the WAIT that ends the 0x01 command.
REQ-020 The refresh loop SHALL issue: ADDR 0x80 command, data for index 0-15, ADDR 0xC0 command, data for index 16-31, and then repeat indefinitely.
REQ-021 FETCH SHALL drive index, hold it for 2 cycles, capture char_in on the 2nd cycle edge, then enter SETUP with rs=1 and the captured byte.
REQ-022 index SHALL increment only in FETCH; it SHALL wrap 31->0 and select ADDR 0x80 before the next fetch.
REQ-023 All counters SHALL be wide enough for the largest parameter; a parameter of 0 SHALL be treated as 1.
REQ-024 char_in changes outside the capture cycle SHALL NOT affect lcd_data.

Reset
REQ-025 With rst high at a clk edge, the FSM SHALL enter PWR, with lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, index=0, init_done=0, and all counters 0.
REQ-026 Reset mid-transaction (including during EHIGH) SHALL drop lcd_e in the next cycle and restart the full init sequence.

Configuration
REQ-027 With LCD_FRAME_PULSE_EN defined, the block SHALL add an output port frame_done (1 bit), high for exactly 1 cycle when the WAIT after the index-31 data write ends; frame_done SHALL reset to 0.
REQ-028 With LCD_FRAME_PULSE_EN undefined, frame_done SHALL be absent and all other behaviour SHALL be identical.

Verification (PWR_WAIT=20, E_PULSE=3, CMD_WAIT=5, CLR_WAIT=10)
REQ-029 Release reset -> lcd_e stays 0 for 20 cycles, then strobes carry 0x38, 0x0C, 0x06, 0x01 with rs=0, each with an e-high of 3 cycles.
REQ-030 Measure gaps -> falling e to the next SETUP is 5 cycles, or 10 after 0x01; init_done rises exactly once.
REQ-031 Source model returns 0x41+index with a 1-cycle registered delay -> lcd_data sequence is 0x80, 0x41..0x50, 0xC0, 0x51..0x60 with rs=1 on the data bytes.
REQ-032 Assert rst during the 2nd EHIGH cycle of a data write -> lcd_e=0 next cycle, index=0, and the sequence restarts at PWR.
REQ-033 Let two frames complete -> index wraps 31->0, and the second frame starts with 0x80; with LCD_FRAME_PULSE_EN, exactly one frame_done pulse occurs per frame.
REQ-034 Toggle char_in every cycle except the capture cycle -> lcd_data equals the captured value for the whole transaction.
